// File: rtl/uart_tx_param_if.sv
// rtl/uart_tx_param_if.sv - host write interface of the parametrised UART transmitter
interface uart_tx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] Tx_DATA;
  logic                 Tx_WR;
  logic                 Tx_EN;
  logic                 Tx_BUSY;
  logic                 Tx_FULL;
  logic                 Tx_DONE;

  modport master (
    output Tx_DATA, Tx_WR, Tx_EN,
    input  Tx_BUSY, Tx_FULL, Tx_DONE
  );

  modport slave (
    input  Tx_DATA, Tx_WR, Tx_EN,
    output Tx_BUSY, Tx_FULL, Tx_DONE
  );
endinterface

// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - parametrised UART transmitter with holding register; line break via UART_TX_BREAK_EN
module uart_tx_param #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int DATA_BITS = 8
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_param_if.slave    host,
  input  logic [2:0]        baud_select,
  input  logic [1:0]        parity_mode,
  input  logic              two_stop,
`ifdef UART_TX_BREAK_EN
  input  logic              Tx_BREAK,
`endif
  output logic              TxD
);

  // Rounded bit-period divisors, one per baud_select code.
  localparam int DIV0 = (CLK_HZ + 150) / 300;
  localparam int DIV1 = (CLK_HZ + 600) / 1200;
  localparam int DIV2 = (CLK_HZ + 2400) / 4800;
  localparam int DIV3 = (CLK_HZ + 4800) / 9600;
  localparam int DIV4 = (CLK_HZ + 9600) / 19200;
  localparam int DIV5 = (CLK_HZ + 19200) / 38400;
  localparam int DIV6 = (CLK_HZ + 28800) / 57600;
  localparam int DIV7 = (CLK_HZ + 57600) / 115200;
  localparam int DW   = (DIV0 > 1) ? $clog2(DIV0) : 1;
  localparam int BW   = $clog2(DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;

  state_t               state_q, state_d;
  logic [DW-1:0]        div_q, div_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 full_q, full_d;
  logic [2:0]           baud_q, baud_d;
  logic [1:0]           par_q, par_d;
  logic                 two_q, two_d;
  logic                 pbit_q, pbit_d;
  logic                 last_div, load, cfg_latch, busy, done;
`ifdef UART_TX_BREAK_EN
  logic [3:0]           brk_q, brk_d;
  logic [3:0]           frame_bits;

  // Minimum break length is one whole frame of the configuration latched at break entry.
  assign frame_bits = 4'(DATA_BITS + 2) + {3'b000, par_q != 2'b00} + {3'b000, two_q};
`endif

  function automatic logic [DW-1:0] div_last_of(input logic [2:0] sel);
    case (sel)
      3'd0:    return DW'(DIV0 - 1);
      3'd1:    return DW'(DIV1 - 1);
      3'd2:    return DW'(DIV2 - 1);
      3'd3:    return DW'(DIV3 - 1);
      3'd4:    return DW'(DIV4 - 1);
      3'd5:    return DW'(DIV5 - 1);
      3'd6:    return DW'(DIV6 - 1);
      default: return DW'(DIV7 - 1);
    endcase
  endfunction

  assign host.Tx_BUSY = busy;
  assign host.Tx_DONE = done;
  assign host.Tx_FULL = full_q;

  // State and datapath registers; reset aborts any frame and leaves the line idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      hold_q  <= '0;
      full_q  <= 1'b0;
      baud_q  <= '0;
      par_q   <= '0;
      two_q   <= 1'b0;
      pbit_q  <= 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
      baud_q  <= baud_d;
      par_q   <= par_d;
      two_q   <= two_d;
      pbit_q  <= pbit_d;
`ifdef UART_TX_BREAK_EN
      brk_q   <= brk_d;
`endif
    end
  end

  // Next-state, holding-register and line-output decode.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    hold_d    = hold_q;
    full_d    = full_q;
    baud_d    = baud_q;
    par_d     = par_q;
    two_d     = two_q;
    pbit_d    = pbit_q;
`ifdef UART_TX_BREAK_EN
    brk_d     = brk_q;
`endif
    TxD       = 1'b1;
    busy      = 1'b0;
    done      = 1'b0;
    load      = 1'b0;
    cfg_latch = 1'b0;
    last_div  = (div_q == div_last_of(baud_q));

    // The write sees the registered full flag, so it never collides with a load.
    if (host.Tx_WR && host.Tx_EN && !full_q) begin
      hold_d = host.Tx_DATA;
      full_d = 1'b1;
    end

    if (state_q != IDLE) div_d = last_div ? '0 : div_q + 1'b1;

    case (state_q)
      IDLE: begin
`ifdef UART_TX_BREAK_EN
        if (Tx_BREAK) begin
          state_d   = BRK;
          div_d     = '0;
          brk_d     = '0;
          cfg_latch = 1'b1;
        end else if (full_q && host.Tx_EN) begin
          load = 1'b1;
        end
`else
        if (full_q && host.Tx_EN) load = 1'b1;
`endif
      end
      START: begin
        TxD  = 1'b0;
        busy = 1'b1;
        if (last_div) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        TxD  = shift_q[0];
        busy = 1'b1;
        if (last_div) begin
          shift_d = shift_q >> 1;
          if (bit_q == BW'(DATA_BITS - 1)) begin
            state_d = (par_q != 2'b00) ? PARITY : STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      PARITY: begin
        TxD  = pbit_q;
        busy = 1'b1;
        if (last_div) state_d = STOP;
      end
      STOP: begin
        busy = 1'b1;
        if (last_div) begin
          if (bit_q == {{(BW-1){1'b0}}, two_q}) begin
            done  = 1'b1;
            bit_d = '0;
            if (full_q && host.Tx_EN) load = 1'b1;
            else state_d = IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      BRK: begin
        TxD  = 1'b0;
        busy = 1'b1;
        if (brk_q == frame_bits) begin
          if (!Tx_BREAK) state_d = IDLE;
        end else if (last_div) begin
          brk_d = brk_q + 4'd1;
          if (brk_q == frame_bits - 4'd1 && !Tx_BREAK) state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // Holding word moves to the shifter; parity is fixed from the word and the mode in force now.
    if (load) begin
      state_d   = START;
      div_d     = '0;
      bit_d     = '0;
      shift_d   = hold_q;
      full_d    = 1'b0;
      cfg_latch = 1'b1;
      case (parity_mode)
        2'b01:   pbit_d = ^hold_q;
        2'b10:   pbit_d = ~^hold_q;
        2'b11:   pbit_d = 1'b1;
        default: pbit_d = 1'b0;
      endcase
    end

    if (cfg_latch) begin
      baud_d = baud_select;
      par_d  = parity_mode;
      two_d  = two_stop;
    end
  end

endmodule
